// File: rtl/lock_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lock_access_ctrl_pkg
//
// Shared definitions for the lock access controller:
//   - ctrl_state_e : session FSM states
//   - DEF_*        : default configuration values
//   - clogMin1()   : index/counter width helper (never returns 0)
//   - ID_W, CNT_W, LOCKOUT_W, FAIL_W : widths for the default configuration
// -----------------------------------------------------------------------------
package lock_access_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        STREAM,
        CHECK,
        REPORT
    } ctrl_state_e;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_CODE_WIDTH     = 8;
    localparam int DEF_ATTEMPT_LEN    = 16;
    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_LOCKOUT_CYCLES = 64;

    // Width able to hold values 0..n-1, at least one bit.
    function automatic int clogMin1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int ID_W      = clogMin1(DEF_NUM_REQ);
    localparam int CNT_W     = clogMin1(DEF_ATTEMPT_LEN);
    localparam int LOCKOUT_W = clogMin1(DEF_LOCKOUT_CYCLES + 1);
    localparam int FAIL_W    = clogMin1(DEF_MAX_FAILS + 1);

endpackage

// File: rtl/lock_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// lock_access_ctrl_if
//
// Bundles the requester bus, the session report and the lock-facing signals.
//   master : requester side plus the lock model (drives req_*, lock_unlocked)
//   slave  : the controller (drives req_ready, grant, done_*, locked_out,
//            lock_reset_n, lock_code)
// -----------------------------------------------------------------------------
interface lock_access_ctrl_if #(
    parameter int NUM_REQ    = lock_access_ctrl_pkg::DEF_NUM_REQ,
    parameter int CODE_WIDTH = lock_access_ctrl_pkg::DEF_CODE_WIDTH,
    parameter int ID_W       = lock_access_ctrl_pkg::ID_W
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*CODE_WIDTH-1:0] req_code;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            grant;
    logic                          done_valid;
    logic [ID_W-1:0]               done_id;
    logic                          done_unlocked;
    logic [NUM_REQ-1:0]            locked_out;
    logic                          lock_reset_n;
    logic [CODE_WIDTH-1:0]         lock_code;
    logic                          lock_unlocked;

    modport master (
        output req_valid, req_code, req_last, lock_unlocked,
        input  req_ready, grant, done_valid, done_id, done_unlocked,
               locked_out, lock_reset_n, lock_code
    );

    modport slave (
        input  req_valid, req_code, req_last, lock_unlocked,
        output req_ready, grant, done_valid, done_id, done_unlocked,
               locked_out, lock_reset_n, lock_code
    );
endinterface

// File: rtl/lock_access_ctrl_arbiter.sv
// -----------------------------------------------------------------------------
// lock_rr_arbiter
//
// Combinational round-robin picker.
//   req_i   : request vector (already masked by lockout)
//   en_i    : allow a pick this cycle
//   ptr_i   : index of the last granted requester
//   grant_o : one-hot winner (all zero when nothing eligible or disabled)
//   idx_o   : binary index of the winner
// -----------------------------------------------------------------------------
module lock_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o
);

    // Search starts just above the last winner and wraps, so the last winner
    // is the final candidate considered.
    always_comb begin
        logic            found;
        logic [ID_W-1:0] pos;
        int              posI;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = '0;
        posI    = 0;
        if (en_i) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                posI = (int'(ptr_i) + k) % NUM_REQ;
                pos  = ID_W'(posI);
                if (!found && req_i[pos]) begin
                    found        = 1'b1;
                    grant_o[pos] = 1'b1;
                    idx_o        = pos;
                end
            end
        end
    end

endmodule

// File: rtl/lock_access_ctrl.sv
// -----------------------------------------------------------------------------
// lock_access_ctrl
//
// Shares one lock between NUM_REQ requesters. A round-robin winner streams one
// attempt of codes into the lock; the lock is held in reset outside STREAM and
// CHECK so each attempt starts fresh. Each attempt ends with a one-cycle
// done_valid report; MAX_FAILS consecutive failures bar the requester for
// LOCKOUT_CYCLES cycles.
//   clk, reset : clock and synchronous active-high reset
//   ctrl_if    : requester bus, session report and lock connection (slave)
// -----------------------------------------------------------------------------
module lock_access_ctrl
    import lock_access_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int CODE_WIDTH     = DEF_CODE_WIDTH,
    parameter int ATTEMPT_LEN    = DEF_ATTEMPT_LEN,
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input logic          clk,
    input logic          reset,
    lock_access_ctrl_if.slave ctrl_if
);

    localparam int IdW   = clogMin1(NUM_REQ);
    localparam int CntW  = clogMin1(ATTEMPT_LEN);
    localparam int LockW = clogMin1(LOCKOUT_CYCLES + 1);
    localparam int FailW = clogMin1(MAX_FAILS + 1);

    ctrl_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q;
    logic [IdW-1:0]       gIdx_q;
    logic [IdW-1:0]       ptr_q;
    logic [CntW-1:0]      cnt_q;
    logic                 result_q;
    logic [FailW-1:0]     failCnt_q [NUM_REQ];
    logic [LockW-1:0]     lockCnt_q [NUM_REQ];

    logic [NUM_REQ-1:0]   lockedOut;
    logic [NUM_REQ-1:0]   arbGrant;
    logic [IdW-1:0]       arbIdx;
    logic                 ownerValid;
    logic                 ownerLast;
    logic [CODE_WIDTH-1:0] ownerCode;
    logic                 handshake;

    // A requester is barred for exactly as long as its counter is nonzero.
    always_comb begin
        lockedOut = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            lockedOut[i] = (lockCnt_q[i] != '0);
        end
    end

    lock_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (IdW)
    ) u_arbiter (
        .req_i   (ctrl_if.req_valid & ~lockedOut),
        .en_i    (state_q == IDLE),
        .ptr_i   (ptr_q),
        .grant_o (arbGrant),
        .idx_o   (arbIdx)
    );

    assign ownerValid = ctrl_if.req_valid[gIdx_q];
    assign ownerLast  = ctrl_if.req_last[gIdx_q];
    assign ownerCode  = ctrl_if.req_code[int'(gIdx_q)*CODE_WIDTH +: CODE_WIDTH];
    assign handshake  = (state_q == STREAM) && ownerValid && !ctrl_if.lock_unlocked;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. In STREAM an unlock wins over a bubble, which wins
    // over the normal end-of-attempt conditions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (arbGrant != '0) state_d = GRANT;
            GRANT:  state_d = STREAM;
            STREAM: begin
                if (ctrl_if.lock_unlocked) begin
                    state_d = REPORT;
                end else if (!ownerValid) begin
                    state_d = REPORT;
                end else if (ownerLast || (cnt_q == CntW'(ATTEMPT_LEN - 1))) begin
                    state_d = CHECK;
                end
            end
            CHECK:  state_d = REPORT;
            REPORT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. The lock only leaves reset while an attempt is streaming
    // or being checked, and is forced back into reset alongside our own.
    always_comb begin
        ctrl_if.req_ready     = '0;
        ctrl_if.lock_code     = '0;
        ctrl_if.lock_reset_n  = 1'b0;
        ctrl_if.done_valid    = 1'b0;
        ctrl_if.done_id       = '0;
        ctrl_if.done_unlocked = 1'b0;
        case (state_q)
            STREAM: begin
                ctrl_if.req_ready[gIdx_q] = !ctrl_if.lock_unlocked;
                ctrl_if.lock_code         = ownerCode;
                ctrl_if.lock_reset_n      = 1'b1;
            end
            CHECK: begin
                ctrl_if.lock_reset_n = 1'b1;
            end
            REPORT: begin
                ctrl_if.done_valid    = 1'b1;
                ctrl_if.done_id       = gIdx_q;
                ctrl_if.done_unlocked = result_q;
            end
            default: ;
        endcase
        if (reset) begin
            ctrl_if.lock_reset_n = 1'b0;
        end
    end

    assign ctrl_if.grant      = grant_q;
    assign ctrl_if.locked_out = lockedOut;

    // Session datapath: owner capture, code counter, attempt result, and the
    // per-requester fail and lockout counters. A lockout load replaces the
    // owner's decrement in the REPORT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q  <= '0;
            gIdx_q   <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            result_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                failCnt_q[i] <= '0;
                lockCnt_q[i] <= '0;
            end
        end else begin
            if ((state_q == IDLE) && (arbGrant != '0)) begin
                grant_q <= arbGrant;
                gIdx_q  <= arbIdx;
                ptr_q   <= arbIdx;
            end
            if (state_q == GRANT) begin
                cnt_q <= '0;
            end else if (handshake) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == STREAM) begin
                if (ctrl_if.lock_unlocked) begin
                    result_q <= 1'b1;
                end else if (!ownerValid) begin
                    result_q <= 1'b0;
                end
            end else if (state_q == CHECK) begin
                result_q <= ctrl_if.lock_unlocked;
            end
            if (state_q == REPORT) begin
                grant_q <= '0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (lockCnt_q[i] != '0) begin
                    lockCnt_q[i] <= lockCnt_q[i] - 1'b1;
                end
                if ((state_q == REPORT) && (IdW'(i) == gIdx_q)) begin
                    if (result_q) begin
                        failCnt_q[i] <= '0;
                    end else if ((int'(failCnt_q[i]) + 1) >= MAX_FAILS) begin
                        failCnt_q[i] <= '0;
                        lockCnt_q[i] <= LockW'(LOCKOUT_CYCLES);
                    end else begin
                        failCnt_q[i] <= failCnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule
